// File: rtl/spike_aer_pkg.sv
// Shared types and constants for the spike address-event encoder.
//   state_t : output serialiser states
//   entry_t : one queued event {timestamp byte, neuron mask byte}
package spike_aer_pkg;
    localparam int BYTE_W  = 8;
    localparam int ENTRY_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_TS   = 2'd1,
        SEND_MASK = 2'd2
    } state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] ts;
        logic [BYTE_W-1:0] mask;
    } entry_t;
endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous event FIFO with first-word fall-through head.
//   clk, rst_n : clock, synchronous active-low reset
//   push, data_in : write request and entry (ignored when full with no pop)
//   pop        : remove head (ignored when empty)
//   full, empty, count : occupancy status
//   head       : current oldest entry, valid whenever !empty
module spike_event_fifo
    import spike_aer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               data_in,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/spike_aer_encoder.sv
// Spike address-event encoder: rising-edge detect on the neuron spike lines,
// timestamp each cycle's event set, queue it, and serialise it as two bytes
// (timestamp, then mask) over a valid/ready byte interface.
//   clk, rst_n      : clock, synchronous active-low reset
//   ena             : enables timestamp advance and event capture
//   spike_in        : neuron spike levels
//   out_ready       : consumer accepts the byte this cycle
//   out_valid/out_data : serialised event byte stream
//   overflow        : sticky, an event was dropped because the FIFO was full
//   clear_overflow  : clears overflow (a same-cycle drop wins)
//   fifo_count      : current FIFO occupancy
module spike_aer_encoder
    import spike_aer_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int TS_WIDTH    = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [NUM_NEURONS-1:0]        spike_in,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [BYTE_W-1:0]             out_data,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_NEURONS-1:0] spike_prev, rise;
    logic [TS_WIDTH-1:0]    ts;
    state_t                 state, state_next;
    entry_t                 new_entry, head;
    logic                   full, empty;
    logic                   push_req, push_acc, pop, drop, remain;

    assign rise      = spike_in & ~spike_prev;
    assign new_entry = '{ts: BYTE_W'(ts), mask: BYTE_W'(rise)};

    assign pop      = (state == SEND_MASK) && out_ready;
    assign push_req = ena && (rise != '0);
    assign push_acc = push_req && (!full || pop);
    assign drop     = push_req && !push_acc;
    // Something is still queued after this cycle's pop, counting a same-cycle push.
    assign remain   = (fifo_count > CW'(1)) || push_acc;

    // spike_prev tracks the lines even while disabled, so edges seen during
    // ena=0 never turn into late events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_prev <= '0;
            ts         <= '0;
            overflow   <= 1'b0;
        end else begin
            spike_prev <= spike_in;
            if (ena) ts <= ts + TS_WIDTH'(1);
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_acc),
        .data_in (new_entry),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count),
        .head    (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!empty)    state_next = SEND_TS;
            SEND_TS:   if (out_ready) state_next = SEND_MASK;
            SEND_MASK: if (out_ready) state_next = remain ? SEND_TS : IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        case (state)
            SEND_TS: begin
                out_valid = 1'b1;
                out_data  = head.ts;
            end
            SEND_MASK: begin
                out_valid = 1'b1;
                out_data  = head.mask;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [3:0] spike = 4'h0;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] got[$];

    spike_aer_encoder #(.NUM_NEURONS(4), .TS_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .spike_in       (spike),
        .out_ready      (rdy),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .overflow       (overflow),
        .clear_overflow (clr),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] spike;
        logic       ena, rdy, clr;
        logic       v;
        logic [7:0] d;
        logic [2:0] c;
        logic       ovf;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic [3:0] s, logic r, logic v, logic [7:0] d, logic [2:0] c);
        vec_t x;
        x.spike = s; x.ena = 1'b1; x.rdy = r; x.clr = 1'b0;
        x.v = v; x.d = d; x.c = c; x.ovf = 1'b0;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic [2:0] c, input logic o);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_count"}, 32'(fifo_count), 32'(c));
        check({tag, "_ovf"},   32'(overflow),  32'(o));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; spike = 4'h0; rdy = 1'b0; clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Accept bytes with ready held high until n have been seen or the budget runs out.
    task automatic collect(input int n, input bit tog, output int steps);
        got.delete();
        steps = 0;
        rdy = 1'b1;
        while (got.size() < n && steps < 40) begin
            if (out_valid) got.push_back(out_data);
            if (tog) spike = spike ^ 4'hF;
            step();
            steps++;
        end
        check("collect_len", 32'(got.size()), 32'(n));
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input int n);
        logic [7:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < n && i < 4; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got.size() > i ? got[i] : 8'hxx), 32'(e[i]));
    endtask

    initial begin
        int st;

        // Single spike at ts=5, simultaneous spikes at ts=9, backpressure at ts=15.
        for (int i = 0; i < 5; i++) tbl[i] = mk(4'h0, 1, 0, 8'h00, 0);
        tbl[5]  = mk(4'h1, 1, 0, 8'h00, 1);
        tbl[6]  = mk(4'h1, 1, 1, 8'h05, 1);
        tbl[7]  = mk(4'h1, 1, 1, 8'h01, 1);
        tbl[8]  = mk(4'h0, 1, 0, 8'h00, 0);
        tbl[9]  = mk(4'hB, 1, 0, 8'h00, 1);
        tbl[10] = mk(4'hB, 1, 1, 8'h09, 1);
        tbl[11] = mk(4'hB, 1, 1, 8'h0B, 1);
        for (int i = 12; i < 15; i++) tbl[i] = mk(4'hB, 1, 0, 8'h00, 0);
        tbl[15] = mk(4'h4, 0, 0, 8'h00, 1);
        for (int i = 16; i < 26; i++) tbl[i] = mk(4'h4, 0, 1, 8'h0F, 1);
        tbl[26] = mk(4'h4, 1, 1, 8'h04, 1);
        tbl[27] = mk(4'h4, 1, 0, 8'h00, 0);

        do_reset();
        check_out("reset", 0, 8'h00, 0, 0);

        for (int i = 0; i < 28; i++) begin
            spike = tbl[i].spike; ena = tbl[i].ena; rdy = tbl[i].rdy; clr = tbl[i].clr;
            step();
            check_out($sformatf("row%0d", i), tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].ovf);
        end

        // Overflow: rising edges at ts 1,3,5,7,9 with the consumer stalled.
        do_reset();
        ena = 1'b1; rdy = 1'b0;
        for (int t = 0; t < 10; t++) begin
            spike = (t % 2 == 1) ? 4'h1 : 4'h0;
            step();
            if (t == 5) check_out("ovf_t5", 1, 8'h01, 3, 0);
            if (t == 7) check_out("ovf_t7", 1, 8'h01, 4, 0);
        end
        check_out("ovf_full", 1, 8'h01, 4, 1);
        spike = 4'h0; step();
        spike = 4'h1; clr = 1'b1; step();      // drop and clear together: set wins
        check("ovf_set_wins", 32'(overflow), 32'd1);
        step();                                 // clear alone, no new edge
        clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_count_kept", 32'(fifo_count), 32'd4);

        // Drain with ena=0 while the spike lines toggle: queued words still leave.
        ena = 1'b0;
        collect(8, 1'b1, st);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_ts%0d", i), 32'(got.size() > 2*i ? got[2*i] : 8'hxx), 32'(2*i + 1));
            check($sformatf("drain_mask%0d", i), 32'(got.size() > 2*i+1 ? got[2*i+1] : 8'hxx), 32'h01);
        end
        check("drain_steps", 32'(st), 32'd8);
        check_out("drained", 0, 8'h00, 0, 0);
        spike = 4'h0; step();
        check("ena0_no_capture", 32'(fifo_count), 32'd0);
        // ts froze at 13 while disabled.
        ena = 1'b1; step();
        spike = 4'h1; step();
        collect(2, 1'b0, st);
        check_bytes("frozen_ts", 8'h0E, 8'h01, 8'h00, 8'h00, 2);

        // Timestamp wrap: events at ts=255 and ts=0 stream back to back.
        do_reset();
        ena = 1'b1; rdy = 1'b1;
        repeat (255) step();
        spike = 4'h1; step();
        spike = 4'h3; step();
        collect(4, 1'b0, st);
        check_bytes("wrap", 8'hFF, 8'h01, 8'h00, 8'h02, 4);
        check("wrap_no_gap", 32'(st), 32'd4);

        // Reset during SEND_MASK with two entries queued.
        do_reset();
        ena = 1'b1; rdy = 1'b0;
        spike = 4'h1; step();
        spike = 4'h3; step();
        check_out("mid_ts", 1, 8'h00, 2, 0);
        rdy = 1'b1; step();
        check_out("mid_mask", 1, 8'h01, 2, 0);
        rdy = 1'b0; rst_n = 1'b0; step();
        check_out("mid_reset", 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        // spike_prev was cleared, so the held lines produce a fresh event at ts=0.
        collect(2, 1'b0, st);
        check_bytes("post_reset", 8'h00, 8'h03, 8'h00, 8'h00, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Downstream consumer of the LIF neuron spike outputs (uo_out[0] and sibling neuron spike lines).
- Detects rising edges on up to 8 spike lines and timestamps each cycle's event set with a free-running counter.
- Buffers events in a small FIFO and serialises them as 2-byte address-event words over a valid/ready byte interface, for off-chip readout through the uio pins.

Parameters:
- NUM_NEURONS, 4, number of spike input lines (1..8).
- TS_WIDTH, 8, timestamp counter width (fixed 8, one output byte).
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  design enable; gates timestamp advance and event capture.
- spike_in  input  NUM_NEURONS  spike lines from neurons, level signals.
- out_ready  input  1  consumer accepts byte this cycle.
- out_valid  output  1  out_data holds a valid byte.
- out_data  output  8  serialised event byte.
- overflow  output  1  sticky: an event was dropped.
- clear_overflow  input  1  clears overflow (synchronous).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - ts=0, spike_prev=0, FIFO empty, FSM=IDLE.
  - out_valid=0, out_data=0, overflow=0, fifo_count=0.
  - Reset mid-transfer aborts the word; the partial word is never resumed.
- Edge detect:
  - rise = spike_in & ~spike_prev.
  - spike_prev <= spike_in every cycle, regardless of ena.
- Timestamp:
  - ts increments by 1 per cycle while ena=1 and wraps 255->0 silently.
  - ts holds while ena=0.
- Capture:
  - If ena=1 and rise!=0 at edge k, push one entry {ts_at_edge_k, rise zero-extended to 8 bits}.
  - All simultaneous rising edges share one entry.
  - With ena=0, edges are ignored; spike_prev still tracks, so no event appears later.
- FIFO full:
  - Push succeeds when not full, or when full and a pop occurs the same cycle.
  - Otherwise the entry is dropped and overflow <= 1.
  - overflow stays set until clear_overflow=1.
  - If clear_overflow=1 and a new drop happen in the same cycle, set wins.
- Output FSM states: IDLE, SEND_TS, SEND_MASK.
  - IDLE -> SEND_TS when the FIFO is non-empty.
  - SEND_TS -> SEND_MASK on out_valid&&out_ready.
  - SEND_MASK -> on out_valid&&out_ready, pop the head. Go to SEND_TS if entries remain after the pop, else IDLE.
  - out_valid=1 exactly in SEND_TS and SEND_MASK.
  - out_data = head.ts in SEND_TS, head.mask in SEND_MASK, 0 in IDLE.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and state hold stable.
  - Transfers are never retracted.
- Latency: rising edge sampled at edge k -> entry written at k -> out_valid=1 with the ts byte after edge k+1. Minimum 2 cycles per event; back-to-back events stream with no idle cycle.
- fifo_count reflects push/pop after each edge; a simultaneous push and pop leaves it unchanged.
- Draining continues while ena=0.

Decomposition:
- Package spike_aer_pkg:
  - state enum (IDLE, SEND_TS, SEND_MASK).
  - constants BYTE_W=8 and ENTRY_W=16.
  - entry typedef {ts[7:0], mask[7:0]}.
- Sub-module spike_event_fifo: synchronous FIFO, depth FIFO_DEPTH, width ENTRY_W. Ports: push, pop, full, empty, count, head; first-word fall-through head.
- Edge detect, timestamp and FSM stay in the top module.

Test Plan:
- Single spike: reset, ena=1, spike_in[0] rises when ts=5 -> bytes 0x05 then 0x01; out_valid high 2 cycles with out_ready=1; then IDLE.
- Simultaneous spikes: spike_in 0000->1011 at ts=9 -> single word 0x09, 0x0B; held spikes (level stays 1) produce no further events.
- Backpressure: out_ready=0 for 10 cycles during SEND_TS -> out_data stays 0x(ts) and out_valid=1; release -> normal completion; fifo_count decrements only on the mask byte.
- Overflow: out_ready=0, 5 distinct rising edges at ts 1,3,5,7,9 with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, drained words carry ts 1,3,5,7; clear_overflow pulse -> overflow=0.
- Wrap and ena: run 260 cycles, spike at ts=255 and at the next cycle -> timestamps 0xFF then 0x00. With ena=0: ts frozen and spikes ignored, but pending entries still drain.
- Reset mid-transfer: assert rst_n=0 during SEND_MASK with 2 entries queued -> next cycle out_valid=0, fifo_count=0, ts=0, overflow=0.
